// File: rtl/wb_ooo_mem_slave.sv
// Wishbone memory slave with tagged responses and address-selected fast/slow latency.
// Define WB_OOO_SLAVE_REORDER_EN for out-of-order completion; by default responses return in request order.
module wb_ooo_mem_slave #(
   parameter int AW       = 8,
   parameter int QDEPTH   = 4,
   parameter int LAT_FAST = 2,
   parameter int LAT_SLOW = 6,
   parameter int SLOW_BIT = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CYC_O,
   input  logic        STB_O,
   input  logic        WE_O,
   input  logic [63:0] ADR_O,
   input  logic [63:0] DAT_O,
   input  logic [7:0]  SEL_O,
   input  logic [15:0] TGA_O,
   output logic [63:0] DAT_I,
   output logic [15:0] TGD_I,
   output logic        ACK_I,
   output logic        ERR_I,
   output logic        RTY_I,
   output logic        RESP_I
);
   localparam int SW = $clog2(QDEPTH);
   localparam int CW = $clog2(LAT_SLOW + 1);

   logic [63:0]       mem_q [2**AW];
   logic [QDEPTH-1:0] valid_q, valid_d;
   logic [QDEPTH-1:0] serr_q, serr_d;
   logic [CW-1:0]     cnt_q [QDEPTH];
   logic [CW-1:0]     cnt_d [QDEPTH];
   logic [15:0]       tag_q [QDEPTH];
   logic [15:0]       tag_d [QDEPTH];
   logic [63:0]       rdata_q [QDEPTH];
   logic [63:0]       rdata_d [QDEPTH];
   logic [63:0]       dat_q, dat_d;
   logic [15:0]       tgd_q, tgd_d;
   logic              ack_q, ack_d, err_q, err_d, rty_q, rty_d, resp_q, resp_d;

   logic              req, full, accept, oor, sel_vld;
   logic [AW-1:0]     widx;
   logic [SW-1:0]     alloc_idx, sel_idx;
   logic [QDEPTH-1:0] elig;
   logic              unused_adr;

   assign req        = CYC_O & STB_O;
   assign full       = &valid_q;
   assign accept     = req & ~full;
   assign oor        = |ADR_O[63:AW+3];
   assign widx       = ADR_O[AW+2:3];
   assign unused_adr = ^ADR_O[2:0];

   // A slot whose counter reaches zero on this edge is already eligible, giving exactly LAT cycles.
   always_comb begin
      alloc_idx = '0;
      elig      = '0;
      for (int i = QDEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_idx = SW'(i);
         elig[i] = valid_q[i] && (cnt_q[i] <= CW'(1));
      end
   end

`ifdef WB_OOO_SLAVE_REORDER_EN
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      for (int i = QDEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_vld = 1'b1;
            sel_idx = SW'(i);
         end
      end
   end
`else
   logic [SW-1:0] age_q [QDEPTH];
   logic [SW-1:0] age_d [QDEPTH];
   logic [SW-1:0] head_q, head_d, tail_q, tail_d;

   function automatic logic [SW-1:0] ptr_inc(input logic [SW-1:0] p);
      return (p == SW'(QDEPTH - 1)) ? '0 : p + SW'(1);
   endfunction

   // Only the oldest outstanding slot may respond; an empty FIFO points at an invalid slot.
   always_comb begin
      sel_idx = age_q[head_q];
      sel_vld = elig[sel_idx];
      age_d   = age_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (sel_vld) head_d = ptr_inc(head_q);
      if (accept) begin
         age_d[tail_q] = alloc_idx;
         tail_d        = ptr_inc(tail_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < QDEPTH; i++) age_q[i] <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         age_q  <= age_d;
      end
   end
`endif

   always_comb begin
      valid_d = valid_q;
      serr_d  = serr_q;
      tag_d   = tag_q;
      rdata_d = rdata_q;
      for (int i = 0; i < QDEPTH; i++)
         cnt_d[i] = (cnt_q[i] == '0) ? '0 : cnt_q[i] - CW'(1);
      if (sel_vld) valid_d[sel_idx] = 1'b0;
      if (accept) begin
         valid_d[alloc_idx] = 1'b1;
         cnt_d[alloc_idx]   = ADR_O[SLOW_BIT] ? CW'(LAT_SLOW) : CW'(LAT_FAST);
         tag_d[alloc_idx]   = TGA_O;
         serr_d[alloc_idx]  = oor;
         rdata_d[alloc_idx] = (WE_O || oor) ? '0 : mem_q[widx];
      end
      resp_d = sel_vld;
      ack_d  = sel_vld & ~serr_q[sel_idx];
      err_d  = sel_vld & serr_q[sel_idx];
      rty_d  = req & full;
      dat_d  = sel_vld ? rdata_q[sel_idx] : '0;
      tgd_d  = sel_vld ? tag_q[sel_idx] : (rty_d ? TGA_O : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         for (int i = 0; i < QDEPTH; i++) cnt_q[i] <= '0;
         dat_q   <= '0;
         tgd_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rty_q   <= 1'b0;
         resp_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
         tgd_q   <= tgd_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rty_q   <= rty_d;
         resp_q  <= resp_d;
      end
   end

   always_ff @(posedge clk) begin
      serr_q  <= serr_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
   end

   always_ff @(posedge clk) begin
      if (accept && WE_O && !oor) begin
         for (int b = 0; b < 8; b++)
            if (SEL_O[b]) mem_q[widx][8*b +: 8] <= DAT_O[8*b +: 8];
      end
   end

   assign DAT_I  = dat_q;
   assign TGD_I  = tgd_q;
   assign ACK_I  = ack_q;
   assign ERR_I  = err_q;
   assign RTY_I  = rty_q;
   assign RESP_I = resp_q;
endmodule

// File: tb/tb_wb_ooo_mem_slave.sv
// Directed bench for wb_ooo_mem_slave; expectations follow the selected ordering mode.
`timescale 1ns/1ps
module tb_wb_ooo_mem_slave;
   logic        clk = 1'b0;
   logic        rst;
   logic        CYC_O, STB_O, WE_O;
   logic [63:0] ADR_O, DAT_O;
   logic [7:0]  SEL_O;
   logic [15:0] TGA_O;
   logic [63:0] DAT_I;
   logic [15:0] TGD_I;
   logic        ACK_I, ERR_I, RTY_I, RESP_I;

`ifdef WB_OOO_SLAVE_REORDER_EN
   localparam bit REORDER = 1'b1;
`else
   localparam bit REORDER = 1'b0;
`endif

   localparam logic [63:0] D_FULL = 64'h1122334455667788;
   localparam logic [63:0] D_PART = 64'h11223344BBBBBBBB;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic stale;

   always #5 clk = ~clk;

   wb_ooo_mem_slave dut (
      .clk(clk), .rst(rst),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
      .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .TGA_O(TGA_O),
      .DAT_I(DAT_I), .TGD_I(TGD_I),
      .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .RESP_I(RESP_I)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // flags are packed as {ACK, ERR, RTY, RESP}
   task automatic chk_out(input string tag, input logic [3:0] flags, input logic [15:0] tgd,
                          input logic [63:0] dat);
      chk({tag, "_flags"}, {ACK_I, ERR_I, RTY_I, RESP_I}, flags);
      chk({tag, "_tgd"}, TGD_I, tgd);
      chk({tag, "_dat"}, DAT_I, dat);
   endtask

   task automatic drive(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                        input logic [7:0] sel, input logic [15:0] tga);
      CYC_O = 1'b1; STB_O = 1'b1; WE_O = we;
      ADR_O = adr;  DAT_O = dat;  SEL_O = sel; TGA_O = tga;
   endtask

   task automatic idle();
      CYC_O = 1'b0; STB_O = 1'b0; WE_O = 1'b0;
      ADR_O = '0;   DAT_O = '0;   SEL_O = '0;  TGA_O = '0;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      step();
      step();
      chk_out("reset", 4'b0000, 16'h0, 64'h0);
      rst = 1'b1;
      step();

      // full write then read-back
      drive(1'b1, 64'h08, D_FULL, 8'hFF, 16'h0001);
      step();
      drive(1'b0, 64'h08, 64'h0, 8'hFF, 16'h0002);
      step();
      chk("t1_quiet", RESP_I, 1'b0);
      idle();
      step();
      chk_out("t1_wr", 4'b1001, 16'h0001, 64'h0);
      step();
      chk_out("t1_rd", 4'b1001, 16'h0002, D_FULL);
      step();
      chk("t1_done", RESP_I, 1'b0);

      // partial write on low four lanes
      drive(1'b1, 64'h08, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 16'h0003);
      step();
      drive(1'b0, 64'h08, 64'h0, 8'hFF, 16'h0004);
      step();
      idle();
      step();
      chk_out("t2_wr", 4'b1001, 16'h0003, 64'h0);
      step();
      chk_out("t2_rd", 4'b1001, 16'h0004, D_PART);
      step();

      // slow then fast read
      drive(1'b0, 64'h40, 64'h0, 8'hFF, 16'h0010);
      step();
      drive(1'b0, 64'h08, 64'h0, 8'hFF, 16'h0011);
      step();
      idle();
      chk("t3_f1", RESP_I, 1'b0);
      step();
      chk("t3_f2", RESP_I, 1'b0);
      step();
      chk_out("t3_f3", REORDER ? 4'b1001 : 4'b0000, REORDER ? 16'h0011 : 16'h0,
              REORDER ? D_PART : 64'h0);
      step();
      step();
      step();
      chk("t3_f6_flags", {ACK_I, RESP_I}, 2'b11);
      chk("t3_f6_tgd", TGD_I, 16'h0010);
      step();
      chk_out("t3_f7", REORDER ? 4'b0000 : 4'b1001, REORDER ? 16'h0 : 16'h0011,
              REORDER ? 64'h0 : D_PART);
      step();
      chk("t3_f8", RESP_I, 1'b0);

      // fill the queue with slow reads, fifth is retried
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 64'h40 + 64'(8 * k), 64'h0, 8'hFF, 16'h0021 + 16'(k));
         step();
         if (k < 4) chk("t4_accept", {RTY_I, RESP_I}, 2'b00);
      end
      chk("t4_rty_flags", {ACK_I, ERR_I, RTY_I, RESP_I}, 4'b0010);
      chk("t4_rty_tgd", TGD_I, 16'h0025);
      idle();
      step();
      chk("t4_rty_once", {RTY_I, RESP_I}, 2'b00);
      drive(1'b0, 64'h78, 64'h0, 8'hFF, 16'h0026);
      step();
      chk("t4_both_flags", {ACK_I, ERR_I, RTY_I, RESP_I}, 4'b1011);
      chk("t4_both_tgd", TGD_I, 16'h0021);
      idle();
      for (int k = 1; k < 4; k++) begin
         step();
         chk("t4_ack_flags", {ACK_I, ERR_I, RTY_I, RESP_I}, 4'b1001);
         chk("t4_ack_tgd", TGD_I, 16'h0021 + 16'(k));
      end
      step();
      chk("t4_done", RESP_I, 1'b0);

      // out-of-range read
      drive(1'b0, 64'h1_0000_0000, 64'h0, 8'hFF, 16'h00EE);
      step();
      idle();
      step();
      chk("t5_quiet", RESP_I, 1'b0);
      step();
      chk_out("t5_err", 4'b0101, 16'h00EE, 64'h0);
      step();

      // reset with requests outstanding
      drive(1'b0, 64'h40, 64'h0, 8'hFF, 16'h0031);
      step();
      drive(1'b0, 64'h48, 64'h0, 8'hFF, 16'h0032);
      step();
      drive(1'b0, 64'h50, 64'h0, 8'hFF, 16'h0033);
      step();
      drive(1'b0, 64'h08, 64'h0, 8'hFF, 16'h0034);
      step();
      idle();
      step();
      step();
      chk("t6_j5_resp", RESP_I, REORDER);
      chk("t6_j5_tgd", TGD_I, REORDER ? 16'h0034 : 16'h0);
      step();
      chk("t6_j6_flags", {ACK_I, RESP_I}, 2'b11);
      chk("t6_j6_tgd", TGD_I, 16'h0031);
      #1;
      rst = 1'b0;
      #1;
      chk_out("t6_async", 4'b0000, 16'h0, 64'h0);
      step();
      step();
      rst = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         stale = stale | RESP_I | RTY_I;
      end
      chk("t6_no_stale", stale, 1'b0);
      drive(1'b0, 64'h08, 64'h0, 8'hFF, 16'h0040);
      step();
      idle();
      step();
      step();
      chk_out("t6_after", 4'b1001, 16'h0040, D_PART);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
